// File: rtl/fifo_prog_pkg.sv
// fifo_prog_pkg -- shared constants and helpers for the programmable FIFO.
//   Default parameter values for fifo_prog and the occupancy-counter width
//   helper.  The counter needs one bit more than the pointers so that it can
//   represent both 0 and DEPTH.
package fifo_prog_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int ADDR_DEF     = 3;
    localparam int AF_LEVEL_DEF = 6;
    localparam int AE_LEVEL_DEF = 2;

    function automatic int cnt_width(input int addr);
        return addr + 1;
    endfunction

endpackage

// File: rtl/fifo_prog_ram.sv
// fifo_prog_ram -- storage array for fifo_prog.
//   DEPTH x WIDTH, one synchronous write port, one asynchronous read port.
//   The array is intentionally not reset; the FIFO's pointers and count
//   decide which entries hold valid data.
// Ports:
//   clk      in  clock
//   we_i     in  write enable
//   waddr_i  in  write address
//   wdata_i  in  write data
//   raddr_i  in  read address
//   rdata_o  out read data (combinational from raddr_i)
module fifo_prog_ram #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [ADDR-1:0]  waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [ADDR-1:0]  raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_prog.sv
// fifo_prog -- synchronous FIFO with programmable almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
// Build option:
//   FIFO_PROG_FWFT_EN  defined   -> first-word-fall-through: read_data shows
//                                   the head word with zero latency.
//                      undefined -> read_data is a register loaded on an
//                                   accepted read (one cycle latency).
// Ports:
//   clk         in  clock, rising edge
//   reset       in  asynchronous active-low reset
//   wen / ren   in  write / read requests
//   write_data  in  word to store
//   read_data   out word read
//   full/empty  out count==DEPTH / count==0
//   af/ae       out count>=AF_LEVEL / count<=AE_LEVEL
//   count       out occupancy 0..DEPTH
//   overflow    out sticky: write rejected
//   underflow   out sticky: read while empty
//   clr_err     in  synchronous clear of both sticky flags
module fifo_prog
    import fifo_prog_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ADDR     = ADDR_DEF,
    parameter int AF_LEVEL = AF_LEVEL_DEF,
    parameter int AE_LEVEL = AE_LEVEL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wen,
    input  logic             ren,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] read_data,
    output logic             full,
    output logic             empty,
    output logic             af,
    output logic             ae,
    output logic [ADDR:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int CW = cnt_width(ADDR);
    localparam int DEPTH = 2**ADDR;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [ADDR-1:0]  wptr_q, wptr_d;
    logic [ADDR-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] ram_rdata;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign af    = (count_q >= AF_C);
    assign ae    = (count_q <= AE_C);
    assign count = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

    // A read that frees a slot in the same cycle lets a write into a full FIFO.
    assign rd_acc = ren && !empty;
    assign wr_acc = wen && (!full || rd_acc);

    always_comb begin
        wptr_d  = wr_acc ? wptr_q + ADDR'(1) : wptr_q;
        rptr_d  = rd_acc ? rptr_q + ADDR'(1) : rptr_q;
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A new error in the same cycle as clr_err wins over the clear.
        ovf_d = (ovf_q && !clr_err) || (wen && !wr_acc);
        udf_d = (udf_q && !clr_err) || (ren && empty);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    fifo_prog_ram #(
        .WIDTH (WIDTH),
        .ADDR  (ADDR)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (write_data),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

`ifdef FIFO_PROG_FWFT_EN
    // Masking while empty keeps the output at zero through reset and never
    // exposes stale array contents.
    assign read_data = empty ? '0 : ram_rdata;
`else
    logic [WIDTH-1:0] rdata_q, rdata_d;

    assign rdata_d = rd_acc ? ram_rdata : rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign read_data = rdata_q;
`endif

endmodule
